pool2_ctrl: RTL and testbench
=============================

// Module: pool2_ctrl
// PURPOSE
//  Sequencer that drives the 16-lane pool2 2x2 max-pool datapath. Scans the 16 parallel f4 maps
//  (10x10) in 2x2 windows, issues f4 read enables/addresses and pool2_clr, and produces f5 (5x5)
//  write enables/addresses. Shared by all 16 lanes; sits between the layer scheduler and the
//  f4/f5 feature-map RAMs.
// PARAMETERS
//  IN_W    10  f4 map width/height (even)
//  OUT_W   5   f5 map width/height (= IN_W/2)
//  RD_LAT  1   f4 RAM read latency in cycles (addr/en at t -> rdata at t+RD_LAT), >=1
//  RA_W    7   f4 read address width (ceil(log2(IN_W*IN_W)))
//  WA_W    5   f5 write address width (ceil(log2(OUT_W*OUT_W)))
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst          in   1     synchronous active-high reset
//  pool2_start  in   1     1-cycle pulse: pool one frame (ignored unless IDLE)
//  pool2_busy   out  1     high from first RUN cycle until pool2_done cycle inclusive
//  pool2_done   out  1     1-cycle pulse after last f5 write
//  f4_rd_en     out  1     read enable to all 16 f4 RAMs
//  f4_raddr     out  RA_W  shared f4 read address
//  pool2_clr    out  1     to datapath: current f4_rdata is first element of a window
//  f5_wr_en     out  1     write enable to all 16 f5 RAMs (datapath d_out valid)
//  f5_waddr     out  WA_W  shared f5 write address
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge.
//  - Reset: state IDLE, all counters/delay lines 0; every output 0.
//  - FSM: IDLE -(start)-> RUN -(last read issued)-> DRAIN -(last write)-> DONE -> IDLE.
//    DONE lasts exactly 1 cycle (pool2_done=1). start in RUN/DRAIN/DONE is ignored.
//  - Counters in RUN: k (0..3, fastest), ox (0..OUT_W-1), oy (0..OUT_W-1, slowest).
//  - RUN: f4_rd_en=1 every cycle, one read per cycle, no bubbles; IN_W*IN_W reads per frame.
//    f4_raddr = (2*oy + k[1])*IN_W + 2*ox + k[0], giving order TL, TR, BL, BR per window.
//  - pool2_clr = (k==0 at issue) delayed RD_LAT cycles, aligned with that element's rdata.
//    Datapath contract: clr -> d_out<=d_in, else d_out<=max(d_out,d_in).
//  - f5_wr_en = (k==3 at issue) delayed RD_LAT+1 cycles; f5_waddr = oy*OUT_W+ox delayed equally.
//    f5_waddr holds 0 when f5_wr_en=0.
//  - Timing, cycle 0 = first RUN cycle (the cycle after start is sampled):
//    reads at cycles 0..99; clr at 4w+RD_LAT; write w at 4w+3+RD_LAT+1; last write at 99+RD_LAT+1;
//    pool2_done at 99+RD_LAT+2; IDLE at the next cycle. start may be accepted again that cycle.
//  - Delay lines are RD_LAT+1-deep shift registers; DRAIN lasts until they are empty.
//  - Address arithmetic is unsigned; products fit RA_W/WA_W by construction, no wrap.
//  - Reset mid-frame: abort immediately, next cycle all outputs 0, no further writes; no done pulse.
//  - start coincident with rst: rst wins.
// TESTING
//  1 rst held 3 cycles -> all outputs 0; pool2_busy=0.
//  2 start pulse, RD_LAT=1 -> f4_raddr cycles 0..7 = 0,1,10,11,2,3,12,13.
//    pool2_clr at cycles 1 and 5. f5_wr_en at cycle 5 (waddr 0) and at 9 (waddr 1).
//  3 same frame, end -> cycles 96..99 raddr 88,89,98,99; f5_wr_en waddr 24 at cycle 101.
//    pool2_done at 102; busy 0 at 103.
//  4 full frame with pool2_exec + RAM models, random 16-bit f4 -> exactly 100 rd_en, 25 clr,
//    25 wr_en; each f5 word = max of its 2x2 window in all 16 lanes.
//  5 start re-pulsed at cycles 20 and 101 -> ignored; frame timing identical to test 3.
//  6 rst at cycle 37 -> outputs 0 from cycle 38, no done; new start -> full correct frame.
//    Repeat tests 2-4 with RD_LAT=2 (all delayed offsets +1).

Source files
------------

// File: rtl/pool2_if.sv
// pool2_if: control/address bundle between the pool2 sequencer and its surroundings
interface pool2_if #(parameter int RA_W = 7, WA_W = 5);
  logic pool2_start, pool2_busy, pool2_done, f4_rd_en, pool2_clr, f5_wr_en;
  logic [RA_W-1:0] f4_raddr;
  logic [WA_W-1:0] f5_waddr;
  modport master (input pool2_start, output pool2_busy, pool2_done, f4_rd_en, f4_raddr, pool2_clr, f5_wr_en, f5_waddr);
  modport slave (output pool2_start, input pool2_busy, pool2_done, f4_rd_en, f4_raddr, pool2_clr, f5_wr_en, f5_waddr);
endinterface

// File: rtl/pool2_ctrl.sv
// pool2_ctrl: 2x2 max-pool sequencer scanning f4 maps and producing f5 write strobes
module pool2_ctrl #(
  parameter int IN_W = 10,
  parameter int OUT_W = 5,
  parameter int RD_LAT = 1,
  parameter int RA_W = 7,
  parameter int WA_W = 5
) (
  input logic clk,
  input logic rst,
  pool2_if.master p
);
  localparam int CW = $clog2(OUT_W + 1);
  localparam logic [CW-1:0] OMAX = CW'(OUT_W - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] k;
  logic [CW-1:0] ox, oy;
  logic [RD_LAT:0] clr_dl, wr_dl;
  logic [RD_LAT:0][WA_W-1:0] wa_dl;
  logic run, last_rd;
  logic [RA_W-1:0] raddr;
  logic [WA_W-1:0] waddr;
  assign run = state == RUN;
  assign last_rd = k == 2'd3 && ox == OMAX && oy == OMAX;
  assign raddr = RA_W'((2 * 32'(oy) + 32'(k[1])) * IN_W + 2 * 32'(ox) + 32'(k[0]));
  assign waddr = WA_W'(32'(oy) * OUT_W + 32'(ox));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // DRAIN ends once only the final write remains in the delay line
  always_comb
    state_n = state == IDLE  ? (p.pool2_start ? RUN : IDLE) :
              state == RUN   ? (last_rd ? DRAIN : RUN) :
              state == DRAIN ? (~|wr_dl[RD_LAT-1:0] ? DONE : DRAIN) : IDLE;
  always_comb begin
    p.pool2_busy = state != IDLE;
    p.pool2_done = state == DONE;
    p.f4_rd_en = run;
    p.f4_raddr = run ? raddr : '0;
    p.pool2_clr = clr_dl[RD_LAT-1];
    p.f5_wr_en = wr_dl[RD_LAT];
    p.f5_waddr = wa_dl[RD_LAT];
  end
  // counters wrap back to zero after the last read, ready for the next frame
  always_ff @(posedge clk)
    if (rst) begin
      k <= '0;
      ox <= '0;
      oy <= '0;
      clr_dl <= '0;
      wr_dl <= '0;
      wa_dl <= '0;
    end else begin
      if (run) begin
        k <= k + 2'd1;
        if (k == 2'd3) ox <= ox == OMAX ? '0 : ox + CW'(1);
        if (k == 2'd3 && ox == OMAX) oy <= oy == OMAX ? '0 : oy + CW'(1);
      end
      clr_dl <= {clr_dl[RD_LAT-1:0], run && k == 2'd0};
      wr_dl <= {wr_dl[RD_LAT-1:0], run && k == 2'd3};
      wa_dl <= {wa_dl[RD_LAT-1:0], (run && k == 2'd3) ? waddr : WA_W'(0)};
    end
endmodule

// File: tb/tb_pool2_ctrl.sv
// tb_pool2_ctrl: checks RD_LAT=1 and RD_LAT=2 sequencers against a cycle-index model plus RAM/max-pool models
module tb_pool2_ctrl;
  logic clk = 0, rst = 1, start = 0, armed = 0;
  int checks = 0, errors = 0, fid = 0;
  always #5 clk = ~clk;

  pool2_if #(.RA_W(7), .WA_W(5)) b1 ();
  pool2_if #(.RA_W(7), .WA_W(5)) b2 ();
  assign b1.pool2_start = start;
  assign b2.pool2_start = start;
  pool2_ctrl #(.IN_W(10), .OUT_W(5), .RD_LAT(1), .RA_W(7), .WA_W(5)) u1 (.clk(clk), .rst(rst), .p(b1.master));
  pool2_ctrl #(.IN_W(10), .OUT_W(5), .RD_LAT(2), .RA_W(7), .WA_W(5)) u2 (.clk(clk), .rst(rst), .p(b2.master));

  logic [1:0] rd_o, clr_o, wr_o, done_o, busy_o;
  logic [6:0] ra_o [2];
  logic [4:0] wa_o [2];
  assign rd_o = {b2.f4_rd_en, b1.f4_rd_en};
  assign clr_o = {b2.pool2_clr, b1.pool2_clr};
  assign wr_o = {b2.f5_wr_en, b1.f5_wr_en};
  assign done_o = {b2.pool2_done, b1.pool2_done};
  assign busy_o = {b2.pool2_busy, b1.pool2_busy};
  assign ra_o[0] = b1.f4_raddr;
  assign ra_o[1] = b2.f4_raddr;
  assign wa_o[0] = b1.f5_waddr;
  assign wa_o[1] = b2.f5_waddr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // cycle index within the current frame per DUT (-1 when idle); frame length is 102+RD_LAT cycles
  int fc [2] = '{-1, -1};
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      fc[d] <= rst ? -1 : fc[d] < 0 ? (start ? 0 : -1) : fc[d] == 102 + d ? -1 : fc[d] + 1;

  function automatic int m_raddr(input int c);
    int w, q;
    if (c < 0 || c > 99) return 0;
    w = c / 4;
    q = c % 4;
    return (2 * (w / 5) + q / 2) * 10 + 2 * (w % 5) + q % 2;
  endfunction

  always @(negedge clk)
    if (armed)
      for (int d = 0; d < 2; d++) begin
        int c, a, b;
        logic wv;
        c = fc[d];
        a = c - (d + 1);
        b = c - (d + 2);
        wv = b >= 0 && b <= 99 && b % 4 == 3;
        chk($sformatf("rd_en[%0d]", d), rd_o[d], int'(c >= 0 && c <= 99));
        chk($sformatf("raddr[%0d]", d), ra_o[d], m_raddr(c));
        chk($sformatf("clr[%0d]", d), clr_o[d], int'(a >= 0 && a <= 99 && a % 4 == 0));
        chk($sformatf("wr_en[%0d]", d), wr_o[d], int'(wv));
        chk($sformatf("waddr[%0d]", d), wa_o[d], wv ? b / 4 : 0);
        chk($sformatf("busy[%0d]", d), busy_o[d], int'(c >= 0));
        chk($sformatf("done[%0d]", d), done_o[d], int'(c == 102 + d));
      end

  // f4 RAMs (latency d+1), pool2 datapath and f5 RAMs driven by the DUT strobes
  logic [15:0] mem [16][128];
  logic [15:0] rq [2][2][16];
  logic [15:0] acc [2][16];
  logic [15:0] f5m [2][32][16];
  int f5_fid [2][32];
  int cnt_rd [2], cnt_clr [2], cnt_wr [2], cnt_done [2];
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 16; l++) begin
        logic [15:0] rdata;
        rdata = rq[d][d][l];
        if (rd_o[d]) rq[d][0][l] <= mem[l][ra_o[d]];
        rq[d][1][l] <= rq[d][0][l];
        acc[d][l] <= (clr_o[d] || rdata > acc[d][l]) ? rdata : acc[d][l];
        if (wr_o[d]) f5m[d][wa_o[d]][l] <= acc[d][l];
      end
      if (wr_o[d]) f5_fid[d][wa_o[d]] <= fid;
      cnt_rd[d] <= cnt_rd[d] + int'(rd_o[d]);
      cnt_clr[d] <= cnt_clr[d] + int'(clr_o[d]);
      cnt_wr[d] <= cnt_wr[d] + int'(wr_o[d]);
      cnt_done[d] <= cnt_done[d] + int'(done_o[d]);
    end

  int s_rd [2], s_clr [2], s_wr [2], s_done [2];
  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_rd[d] = cnt_rd[d];
      s_clr[d] = cnt_clr[d];
      s_wr[d] = cnt_wr[d];
      s_done[d] = cnt_done[d];
    end
  endtask

  task automatic fill();
    for (int l = 0; l < 16; l++)
      for (int a = 0; a < 128; a++) mem[l][a] = 16'($urandom);
  endtask

  task automatic check_frame(input int f);
    for (int d = 0; d < 2; d++) begin
      chk("n_rd", cnt_rd[d] - s_rd[d], 100);
      chk("n_clr", cnt_clr[d] - s_clr[d], 25);
      chk("n_wr", cnt_wr[d] - s_wr[d], 25);
      chk("n_done", cnt_done[d] - s_done[d], 1);
      for (int w = 0; w < 25; w++) begin
        int base;
        base = (w / 5) * 20 + (w % 5) * 2;
        chk("f5_written", f5_fid[d][w], f);
        for (int l = 0; l < 16; l++) begin
          logic [15:0] m;
          m = mem[l][base];
          if (mem[l][base + 1] > m) m = mem[l][base + 1];
          if (mem[l][base + 10] > m) m = mem[l][base + 10];
          if (mem[l][base + 11] > m) m = mem[l][base + 11];
          chk($sformatf("f5_max d%0d w%0d l%0d", d, w, l), f5m[d][w][l], m);
        end
      end
    end
  endtask

  logic [6:0] lo [8] = '{7'd0, 7'd1, 7'd10, 7'd11, 7'd2, 7'd3, 7'd12, 7'd13};
  logic [6:0] hi [4] = '{7'd88, 7'd89, 7'd98, 7'd99};

  initial begin
    fill();
    repeat (3) @(posedge clk);
    armed = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy_o[d], 0);
      chk("rst_rd", rd_o[d], 0);
      chk("rst_wr", wr_o[d], 0);
      chk("rst_done", done_o[d], 0);
    end
    rst = 0;
    // frame 1: pinned timing, start re-pulsed at 20 and 101
    @(negedge clk);
    fid = 1;
    snap();
    start = 1;
    for (int n = 0; n <= 105; n++) begin
      @(negedge clk);
      start = n == 20 || n == 101;
      for (int d = 0; d < 2; d++) begin
        int L;
        L = d + 1;
        if (n < 8) chk("lit_raddr_lo", ra_o[d], lo[n]);
        if (n >= 96 && n <= 99) chk("lit_raddr_hi", ra_o[d], hi[n - 96]);
        if (n == L || n == 4 + L) chk("lit_clr", clr_o[d], 1);
        if (n == L + 1) chk("lit_clr_off", clr_o[d], 0);
        if (n == 4 + L || n == 8 + L || n == 100 + L) chk("lit_wr", wr_o[d], 1);
        if (n == 4 + L) chk("lit_waddr0", wa_o[d], 0);
        if (n == 8 + L) chk("lit_waddr1", wa_o[d], 1);
        if (n == 100 + L) chk("lit_waddr24", wa_o[d], 24);
        if (n == 101 + L) chk("lit_done", done_o[d], 1);
        if (n == 102 + L) chk("lit_idle_busy", busy_o[d], 0);
      end
    end
    check_frame(1);
    // frame 2: aborted by reset at cycle 37
    fill();
    fid = 2;
    snap();
    start = 1;
    for (int n = 0; n <= 37; n++) begin
      @(negedge clk);
      start = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", busy_o[d], 0);
      chk("abort_rd", rd_o[d], 0);
      chk("abort_clr", clr_o[d], 0);
      chk("abort_wr", wr_o[d], 0);
    end
    repeat (110) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("abort_no_done", cnt_done[d] - s_done[d], 0);
    // frame 3: full frame after the abort
    fill();
    fid = 3;
    snap();
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (110) @(negedge clk);
    check_frame(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
